excp_unit: RTL and testbench

EXCP_UNIT -- requirements
Module: excp_unit

---
 rtl/excp_unit.sv | 198 +++++++++++++++++++
 tb/tb_excp_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_unit.sv
// Exception/interrupt unit: picks one winner per MEM-stage event, drives CP0 commit strobes and the fetch redirect.
// Latency: outputs registered, one cycle after the sampling edge; hw_int_sync two cycles after hw_int.
// Backpressure: none; after an event, FLUSH and BLANK states ignore mem_valid, so flush pulses are at least 3 cycles apart.
module excp_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  hw_int,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic [31:0] mem_badvaddr,
  input  logic        mem_eret,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  hw_int_sync,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exc_code,
  output logic        cp0_exc_bd,
  output logic        cp0_epc_we,
  // EPC write value; named apart from the cp0_epc input, which carries the current EPC.
  output logic [31:0] cp0_epc_wdata,
  output logic        cp0_bva_we,
  output logic [31:0] cp0_bva,
  output logic        cp0_eret_we
);

  typedef enum logic [1:0] {IDLE, FLUSH, BLANK} state_t;

  // mem_exc bit positions
  localparam int ADEL_IF = 0;
  localparam int RI      = 1;
  localparam int SYS     = 2;
  localparam int BRK     = 3;
  localparam int OV      = 4;
  localparam int ADEL_D  = 5;
  localparam int ADES    = 6;

  state_t      state_q, state_d;
  logic [5:0]  sync1_q, sync2_q;

  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        exc_we_q, exc_we_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        exc_bd_q, exc_bd_d;
  logic        epc_we_q, epc_we_d;
  logic [31:0] epc_q, epc_d;
  logic        bva_we_q, bva_we_d;
  logic [31:0] bva_q, bva_d;
  logic        eret_we_q, eret_we_d;

  logic        st_ie, st_exl;
  logic [5:0]  st_im;
  logic        int_req;
  logic        exc_any;
  logic        event_ok;
  logic [4:0]  win_code;
  logic        win_bva_we;
  logic [31:0] win_bva;
  logic        unused_status;

  assign st_ie         = cp0_status[0];
  assign st_exl        = cp0_status[1];
  assign st_im         = cp0_status[15:10];
  assign unused_status = ^{cp0_status[31:16], cp0_status[9:2]};

  assign hw_int_sync = sync2_q;
  assign int_req     = (|(sync2_q & st_im)) & st_ie & ~st_exl;
  assign exc_any     = int_req | (|mem_exc);
  assign event_ok    = (state_q == IDLE) && mem_valid;

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 6'b0;
      sync2_q <= 6'b0;
    end else begin
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
    end
  end

  // Fixed-priority winner selection: ExcCode and BadVAddr source
  always_comb begin
    win_code   = 5'd0;
    win_bva_we = 1'b0;
    win_bva    = 32'h0;
    if (int_req) begin
      win_code = 5'd0;
    end else if (mem_exc[ADEL_IF]) begin
      win_code   = 5'd4;
      win_bva_we = 1'b1;
      win_bva    = mem_pc;
    end else if (mem_exc[RI]) begin
      win_code = 5'd10;
    end else if (mem_exc[SYS]) begin
      win_code = 5'd8;
    end else if (mem_exc[BRK]) begin
      win_code = 5'd9;
    end else if (mem_exc[OV]) begin
      win_code = 5'd12;
    end else if (mem_exc[ADEL_D]) begin
      win_code   = 5'd4;
      win_bva_we = 1'b1;
      win_bva    = mem_badvaddr;
    end else if (mem_exc[ADES]) begin
      win_code   = 5'd5;
      win_bva_we = 1'b1;
      win_bva    = mem_badvaddr;
    end
  end

  // Next-state and next-output logic; outputs default to zero so every strobe is a single-cycle pulse
  always_comb begin
    state_d       = state_q;
    flush_d       = 1'b0;
    redirect_pc_d = 32'h0;
    exc_we_d      = 1'b0;
    exc_code_d    = 5'd0;
    exc_bd_d      = 1'b0;
    epc_we_d      = 1'b0;
    epc_d         = 32'h0;
    bva_we_d      = 1'b0;
    bva_d         = 32'h0;
    eret_we_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (event_ok && exc_any) begin
          state_d       = FLUSH;
          flush_d       = 1'b1;
          redirect_pc_d = EXC_VECTOR;
          exc_we_d      = 1'b1;
          exc_code_d    = win_code;
          exc_bd_d      = mem_bd;
          epc_we_d      = ~st_exl;
          epc_d         = mem_bd ? (mem_pc - 32'd4) : mem_pc;
          bva_we_d      = win_bva_we;
          bva_d         = win_bva;
        end else if (event_ok && mem_eret) begin
          state_d       = FLUSH;
          flush_d       = 1'b1;
          redirect_pc_d = cp0_epc;
          eret_we_d     = 1'b1;
        end
      end
      FLUSH:   state_d = BLANK;
      BLANK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flush_q       <= 1'b0;
      redirect_pc_q <= 32'h0;
      exc_we_q      <= 1'b0;
      exc_code_q    <= 5'd0;
      exc_bd_q      <= 1'b0;
      epc_we_q      <= 1'b0;
      epc_q         <= 32'h0;
      bva_we_q      <= 1'b0;
      bva_q         <= 32'h0;
      eret_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      exc_we_q      <= exc_we_d;
      exc_code_q    <= exc_code_d;
      exc_bd_q      <= exc_bd_d;
      epc_we_q      <= epc_we_d;
      epc_q         <= epc_d;
      bva_we_q      <= bva_we_d;
      bva_q         <= bva_d;
      eret_we_q     <= eret_we_d;
    end
  end

  assign flush         = flush_q;
  assign redirect_pc   = redirect_pc_q;
  assign cp0_exc_we    = exc_we_q;
  assign cp0_exc_code  = exc_code_q;
  assign cp0_exc_bd    = exc_bd_q;
  assign cp0_epc_we    = epc_we_q;
  assign cp0_epc_wdata = epc_q;
  assign cp0_bva_we    = bva_we_q;
  assign cp0_bva       = bva_q;
  assign cp0_eret_we   = eret_we_q;

endmodule

// File: tb/tb_excp_unit.sv
// Directed bench for excp_unit: vector table for single events, hand sequences for multi-cycle cases.
// Latency: checks outputs on the negedge following the sampling posedge.
// Backpressure: n/a.
module tb_excp_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  hw_int;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_badvaddr;
  logic        mem_eret;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic [5:0]  hw_int_sync;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        cp0_exc_we;
  logic [4:0]  cp0_exc_code;
  logic        cp0_exc_bd;
  logic        cp0_epc_we;
  logic [31:0] cp0_epc_wdata;
  logic        cp0_bva_we;
  logic [31:0] cp0_bva;
  logic        cp0_eret_we;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  excp_unit #(.EXC_VECTOR(32'h8000_0180)) dut (
    .clk(clk), .rst_n(rst_n), .hw_int(hw_int),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd), .mem_exc(mem_exc),
    .mem_badvaddr(mem_badvaddr), .mem_eret(mem_eret),
    .cp0_status(cp0_status), .cp0_epc(cp0_epc),
    .hw_int_sync(hw_int_sync), .flush(flush), .redirect_pc(redirect_pc),
    .cp0_exc_we(cp0_exc_we), .cp0_exc_code(cp0_exc_code), .cp0_exc_bd(cp0_exc_bd),
    .cp0_epc_we(cp0_epc_we), .cp0_epc_wdata(cp0_epc_wdata),
    .cp0_bva_we(cp0_bva_we), .cp0_bva(cp0_bva), .cp0_eret_we(cp0_eret_we)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  exc;
    logic [31:0] badva;
    logic        eret;
    logic [31:0] status;
    logic [31:0] epc_in;
    logic        e_flush;
    logic        e_exc_we;
    logic [4:0]  e_code;
    logic        e_bd;
    logic        e_epc_we;
    logic [31:0] e_epc;
    logic        e_bva_we;
    logic [31:0] e_bva;
    logic        e_eret_we;
    logic [31:0] e_redir;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flush"}, {31'b0, flush}, 32'h0);
    chk({tag, "_redir"}, redirect_pc, 32'h0);
    chk({tag, "_exc_we"}, {31'b0, cp0_exc_we}, 32'h0);
    chk({tag, "_code"}, {27'b0, cp0_exc_code}, 32'h0);
    chk({tag, "_bd"}, {31'b0, cp0_exc_bd}, 32'h0);
    chk({tag, "_epc_we"}, {31'b0, cp0_epc_we}, 32'h0);
    chk({tag, "_epc"}, cp0_epc_wdata, 32'h0);
    chk({tag, "_bva_we"}, {31'b0, cp0_bva_we}, 32'h0);
    chk({tag, "_bva"}, cp0_bva, 32'h0);
    chk({tag, "_eret_we"}, {31'b0, cp0_eret_we}, 32'h0);
  endtask

  task automatic clear_in();
    mem_valid    = 1'b0;
    mem_pc       = 32'h0;
    mem_bd       = 1'b0;
    mem_exc      = 7'h0;
    mem_badvaddr = 32'h0;
    mem_eret     = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    mem_valid    = v.valid;
    mem_pc       = v.pc;
    mem_bd       = v.bd;
    mem_exc      = v.exc;
    mem_badvaddr = v.badva;
    mem_eret     = v.eret;
    cp0_status   = v.status;
    cp0_epc      = v.epc_in;
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, "_flush"}, {31'b0, flush}, {31'b0, v.e_flush});
    chk({tag, "_redir"}, redirect_pc, v.e_redir);
    chk({tag, "_exc_we"}, {31'b0, cp0_exc_we}, {31'b0, v.e_exc_we});
    chk({tag, "_code"}, {27'b0, cp0_exc_code}, {27'b0, v.e_code});
    chk({tag, "_bd"}, {31'b0, cp0_exc_bd}, {31'b0, v.e_bd});
    chk({tag, "_epc_we"}, {31'b0, cp0_epc_we}, {31'b0, v.e_epc_we});
    chk({tag, "_epc"}, cp0_epc_wdata, v.e_epc);
    chk({tag, "_bva_we"}, {31'b0, cp0_bva_we}, {31'b0, v.e_bva_we});
    chk({tag, "_bva"}, cp0_bva, v.e_bva);
    chk({tag, "_eret_we"}, {31'b0, cp0_eret_we}, {31'b0, v.e_eret_we});
  endtask

  initial begin
    localparam logic [31:0] EV = 32'h8000_0180;
    // valid pc bd exc badva eret status epc_in | flush exc_we code bd epc_we epc bva_we bva eret_we redir
    vecs[0]  = '{1, 32'hBFC0_0010, 0, 7'b0000100, 32'h0, 0, 32'h0, 32'h0,
                 1, 1, 5'd8, 0, 1, 32'hBFC0_0010, 0, 32'h0, 0, EV};
    vecs[1]  = '{1, 32'h0000_0000, 1, 7'b1000000, 32'h1003, 0, 32'h0, 32'h0,
                 1, 1, 5'd5, 1, 1, 32'hFFFF_FFFC, 1, 32'h1003, 0, EV};
    vecs[2]  = '{1, 32'h0040_0004, 0, 7'b0000011, 32'h5555, 0, 32'h0, 32'h0,
                 1, 1, 5'd4, 0, 1, 32'h0040_0004, 1, 32'h0040_0004, 0, EV};
    vecs[3]  = '{1, 32'h0040_0100, 0, 7'b0000110, 32'h0, 0, 32'h0, 32'h0,
                 1, 1, 5'd10, 0, 1, 32'h0040_0100, 0, 32'h0, 0, EV};
    vecs[4]  = '{1, 32'h0040_0200, 0, 7'b0001100, 32'h0, 0, 32'h0, 32'h0,
                 1, 1, 5'd8, 0, 1, 32'h0040_0200, 0, 32'h0, 0, EV};
    vecs[5]  = '{1, 32'h0040_0300, 0, 7'b0011000, 32'h0, 0, 32'h0, 32'h0,
                 1, 1, 5'd9, 0, 1, 32'h0040_0300, 0, 32'h0, 0, EV};
    vecs[6]  = '{1, 32'h0040_0400, 0, 7'b0110000, 32'h77, 0, 32'h0, 32'h0,
                 1, 1, 5'd12, 0, 1, 32'h0040_0400, 0, 32'h0, 0, EV};
    vecs[7]  = '{1, 32'h0040_0500, 0, 7'b1100000, 32'hA000_0003, 0, 32'h0, 32'h0,
                 1, 1, 5'd4, 0, 1, 32'h0040_0500, 1, 32'hA000_0003, 0, EV};
    vecs[8]  = '{1, 32'h0040_0600, 0, 7'b0010000, 32'h0, 0, 32'h2, 32'h0,
                 1, 1, 5'd12, 0, 0, 32'h0040_0600, 0, 32'h0, 0, EV};
    vecs[9]  = '{1, 32'h0040_0700, 0, 7'b0000000, 32'h0, 1, 32'h2, 32'h8000_1234,
                 1, 0, 5'd0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8000_1234};
    vecs[10] = '{1, 32'h0040_0800, 0, 7'b0000100, 32'h0, 1, 32'h0, 32'h8000_1234,
                 1, 1, 5'd8, 0, 1, 32'h0040_0800, 0, 32'h0, 0, EV};
    vecs[11] = '{0, 32'h0040_0900, 0, 7'b0000100, 32'h0, 1, 32'h0, 32'h8000_1234,
                 0, 0, 5'd0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0};
    vecs[12] = '{1, 32'h0000_1000, 1, 7'b0001000, 32'h0, 0, 32'h0, 32'h0,
                 1, 1, 5'd9, 1, 1, 32'h0000_0FFC, 0, 32'h0, 0, EV};

    // Reset state; interrupt lines high must not leak through while in reset
    rst_n      = 1'b0;
    hw_int     = 6'h3F;
    cp0_status = 32'h0;
    cp0_epc    = 32'h0;
    clear_in();
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    chk("rst_sync", {26'b0, hw_int_sync}, 32'h0);
    hw_int = 6'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single-event vectors: result one cycle after sampling, gone the cycle after
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(negedge clk);
      chk_vec($sformatf("v%0d", i), vecs[i]);
      clear_in();
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), {31'b0, flush}, 32'h0);
      @(negedge clk);
    end

    // Interrupt beats RI on the same instruction, two cycles after hw_int rises
    @(negedge clk);
    cp0_status = 32'h0000_1001;
    hw_int     = 6'b000100;
    @(negedge clk);
    chk("int_sync_1cyc", {26'b0, hw_int_sync}, 32'h0);
    @(negedge clk);
    chk("int_sync_2cyc", {26'b0, hw_int_sync}, 32'h4);
    mem_valid = 1'b1;
    mem_pc    = 32'h8000_0100;
    mem_exc   = 7'b0000010;
    @(negedge clk);
    chk("int_flush", {31'b0, flush}, 32'h1);
    chk("int_code", {27'b0, cp0_exc_code}, 32'h0);
    chk("int_exc_we", {31'b0, cp0_exc_we}, 32'h1);
    chk("int_epc", cp0_epc_wdata, 32'h8000_0100);
    chk("int_bva_we", {31'b0, cp0_bva_we}, 32'h0);
    clear_in();
    repeat (3) @(negedge clk);

    // EXL=1 masks a pending interrupt: valid instruction without flags raises nothing
    cp0_status = 32'h0000_1003;
    mem_valid  = 1'b1;
    mem_pc     = 32'h8000_0200;
    @(negedge clk);
    chk("exl_int_flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    chk("exl_int_flush2", {31'b0, flush}, 32'h0);
    clear_in();
    hw_int = 6'h0;
    repeat (4) @(negedge clk);

    // Interrupt rising during FLUSH/BLANK is taken on the first IDLE instruction
    cp0_status = 32'h0000_1001;
    cp0_epc    = 32'h8000_2000;
    mem_valid  = 1'b1;
    mem_pc     = 32'h8000_0300;
    mem_eret   = 1'b1;
    @(negedge clk);
    chk("hold_eret_flush", {31'b0, flush}, 32'h1);
    chk("hold_eret_redir", redirect_pc, 32'h8000_2000);
    mem_eret = 1'b0;
    hw_int   = 6'b000100;
    @(negedge clk);
    chk("hold_blank_flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    chk("hold_idle_flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    chk("hold_int_flush", {31'b0, flush}, 32'h1);
    chk("hold_int_code", {27'b0, cp0_exc_code}, 32'h0);
    chk("hold_int_exc_we", {31'b0, cp0_exc_we}, 32'h1);
    clear_in();
    hw_int     = 6'h0;
    cp0_status = 32'h0;
    repeat (4) @(negedge clk);

    // ERET followed by wrong-path exception flags held for two cycles: no second pulse
    mem_valid = 1'b1;
    mem_pc    = 32'h8000_0400;
    mem_eret  = 1'b1;
    cp0_epc   = 32'h8000_1234;
    @(negedge clk);
    chk("eret_flush", {31'b0, flush}, 32'h1);
    chk("eret_we", {31'b0, cp0_eret_we}, 32'h1);
    chk("eret_exc_we", {31'b0, cp0_exc_we}, 32'h0);
    chk("eret_redir", redirect_pc, 32'h8000_1234);
    mem_eret = 1'b0;
    mem_exc  = 7'b0000100;
    @(negedge clk);
    chk("eret_wp1_flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    chk("eret_wp2_flush", {31'b0, flush}, 32'h0);
    clear_in();
    @(negedge clk);
    chk("eret_wp3_flush", {31'b0, flush}, 32'h0);
    chk("eret_wp3_exc_we", {31'b0, cp0_exc_we}, 32'h0);
    repeat (2) @(negedge clk);

    // Reset asserted during the flush cycle clears outputs at once; no residue after release
    mem_valid = 1'b1;
    mem_pc    = 32'h8000_0500;
    mem_exc   = 7'b0000100;
    @(negedge clk);
    chk("rstmid_flush_before", {31'b0, flush}, 32'h1);
    clear_in();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_after1", {31'b0, flush}, 32'h0);
    @(negedge clk);
    chk("rstmid_after2", {31'b0, flush}, 32'h0);
    // Immediately back in IDLE: a new event is accepted on the first try
    mem_valid = 1'b1;
    mem_pc    = 32'h8000_0600;
    mem_exc   = 7'b0001000;
    @(negedge clk);
    chk("rstmid_idle_flush", {31'b0, flush}, 32'h1);
    chk("rstmid_idle_code", {27'b0, cp0_exc_code}, 32'd9);
    clear_in();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
